// File: rtl/sram_bus_pkg.sv
// Shared SRAM-like bus definitions: size encodings, lock states and a width helper.
package sram_bus_pkg;

  localparam int unsigned SRAM_SIZE_W = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sram_size_e;

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned clog2_safe(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sram_bridge_nx1_if.sv
// Bundle of the N upstream SRAM-like request ports and the single downstream port.
interface sram_bridge_nx1_if
  import sram_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
);

  logic [NUM_MASTERS-1:0]             m_req;
  logic [NUM_MASTERS-1:0]             m_wr;
  logic [SRAM_SIZE_W*NUM_MASTERS-1:0] m_size;
  logic [ADDR_W*NUM_MASTERS-1:0]      m_addr;
  logic [DATA_W*NUM_MASTERS-1:0]      m_wdata;
  logic [NUM_MASTERS-1:0]             m_addr_ok;
  logic [NUM_MASTERS-1:0]             m_data_ok;
  logic [DATA_W-1:0]                  m_rdata;

  logic                               s_req;
  logic                               s_wr;
  logic [SRAM_SIZE_W-1:0]             s_size;
  logic [ADDR_W-1:0]                  s_addr;
  logic [DATA_W-1:0]                  s_wdata;
  logic [DATA_W-1:0]                  s_rdata;
  logic                               s_addr_ok;
  logic                               s_data_ok;

  // Bridge side: consumes upstream requests, drives the downstream port.
  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_rdata, s_addr_ok, s_data_ok
  );

  // Environment side: upstream masters plus the downstream memory.
  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_rdata, s_addr_ok, s_data_ok
  );

endinterface

// File: rtl/sram_bridge_nx1_id_fifo.sv
// Circular FIFO with wrap-bit pointers; holds master indices of in-flight requests.
module id_fifo
  import sram_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [clog2_safe(DEPTH):0]  count
);

  localparam int unsigned AW = clog2_safe(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

endmodule

// File: rtl/sram_bridge_nx1.sv
// N-to-1 SRAM-like bridge: round-robin arbitration with grant lock, in-order
// response routing through an ID FIFO allowing several outstanding requests.
module sram_bridge_nx1
  import sram_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 3,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  sram_bridge_nx1_if.slave                     bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 protocol_err
);

  localparam int unsigned IDX_W = clog2_safe(NUM_MASTERS);

  lock_state_e            state;
  lock_state_e            state_nxt;
  logic [IDX_W-1:0]       lock_idx;
  logic [IDX_W-1:0]       lock_idx_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_ptr_nxt;
  logic                   err_nxt;

  logic [IDX_W-1:0]       rr_pick;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic [IDX_W-1:0]       sel;

  logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];
  logic [SRAM_SIZE_W-1:0] size_arr  [NUM_MASTERS];

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [IDX_W-1:0]       fifo_head;
  logic                   fifo_block;
  logic                   pop;
  logic                   accept;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i]  = bus.m_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = bus.m_wdata[i*DATA_W +: DATA_W];
      size_arr[i]  = bus.m_size[i*SRAM_SIZE_W +: SRAM_SIZE_W];
    end
  end

  // First requesting master at or after rr_ptr, wrapping; rr_ptr if none.
  always_comb begin
    rr_pick = rr_ptr;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_MASTERS);
      if (!found && bus.m_req[cand]) begin
        found   = 1'b1;
        rr_pick = cand;
      end
    end
  end

  assign sel = (state == LOCK_HELD) ? lock_idx : rr_pick;

  assign pop        = bus.s_data_ok & ~fifo_empty;
  assign fifo_block = fifo_full & ~pop;
  // Gated by reset so no downstream request escapes while the bridge is held in reset.
  assign bus.s_req  = bus.m_req[sel] & ~fifo_block & aresetn;
  assign accept     = bus.s_req & bus.s_addr_ok;

  assign bus.s_wr    = bus.m_wr[sel];
  assign bus.s_size  = size_arr[sel];
  assign bus.s_addr  = addr_arr[sel];
  assign bus.s_wdata = wdata_arr[sel];
  assign bus.m_rdata = bus.s_rdata;

  always_comb begin
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      bus.m_addr_ok[i] = accept && (sel == IDX_W'(i));
      bus.m_data_ok[i] = pop && (fifo_head == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    rr_ptr_nxt   = rr_ptr;
    err_nxt      = protocol_err;

    if (bus.s_data_ok && fifo_empty) err_nxt = 1'b1;

    if (accept) begin
      rr_ptr_nxt = (sel == IDX_W'(NUM_MASTERS-1)) ? '0 : sel + IDX_W'(1);
    end

    unique case (state)
      LOCK_FREE: begin
        if (bus.s_req && !bus.s_addr_ok) begin
          state_nxt    = LOCK_HELD;
          lock_idx_nxt = sel;
        end
      end
      LOCK_HELD: begin
        // A locked master withdrawing its request breaks the SRAM-like handshake.
        if (!bus.m_req[lock_idx]) begin
          state_nxt = LOCK_FREE;
          err_nxt   = 1'b1;
        end else if (accept) begin
          state_nxt = LOCK_FREE;
        end
      end
      default: state_nxt = LOCK_FREE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= LOCK_FREE;
      lock_idx     <= '0;
      rr_ptr       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      lock_idx     <= lock_idx_nxt;
      rr_ptr       <= rr_ptr_nxt;
      protocol_err <= err_nxt;
    end
  end

  id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (accept),
    .push_data (sel),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule

// File: doc/sram_bridge_nx1.md
Name: sram_bridge_nx1

Overview:
- Parametrised N-to-1 SRAM-like bus arbiter: merges NUM_MASTERS request ports onto one downstream SRAM-like port.
- Successor to the fixed 2x1 data bridge. Adds round-robin arbitration, grant locking, and multiple outstanding transactions.
- Responses are routed back in order through an internal ID FIFO.
- Sits between caches/uncached paths and cpu_axi_interface.

Parameters:
- NUM_MASTERS, 3, number of upstream request ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 4, accepted-but-unanswered transactions tracked (power of 2, >=2)
- IDX_W, $clog2(NUM_MASTERS), master index width (derived)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- m_req  in  NUM_MASTERS  per-master request
- m_wr  in  NUM_MASTERS  per-master write flag
- m_size  in  2*NUM_MASTERS  per-master size, master i at [2i+1:2i]
- m_addr  in  ADDR_W*NUM_MASTERS  per-master address
- m_wdata  in  DATA_W*NUM_MASTERS  per-master write data
- m_addr_ok  out  NUM_MASTERS  address accepted, one-hot or zero
- m_data_ok  out  NUM_MASTERS  response valid, one-hot or zero
- m_rdata  out  DATA_W  read data, broadcast to all masters (qualified by m_data_ok)
- s_req  out  1  downstream request
- s_wr  out  1  downstream write flag
- s_size  out  2  downstream size
- s_addr  out  ADDR_W  downstream address
- s_wdata  out  DATA_W  downstream write data
- s_rdata  in  DATA_W  downstream read data
- s_addr_ok  in  1  downstream address accepted
- s_data_ok  in  1  downstream response
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
- protocol_err  out  1  sticky error flag

Behaviour:
- Clocking/reset: one clock (aclk). Reset aresetn is asynchronous, active-low. All state clears immediately on assertion.
- Reset values: rr_ptr=0, lock_valid=0, lock_idx=0, FIFO empty, outstanding=0, protocol_err=0. Consequently s_req=0, m_addr_ok=0, m_data_ok=0, and s_* data outputs pass through master 0.
- Selection (combinational):
  - If lock_valid, sel=lock_idx.
  - Else sel = first master with m_req set, searching from rr_ptr upward modulo NUM_MASTERS.
  - If no request, sel=rr_ptr.
- Downstream drive:
  - s_req = m_req[sel] & ~fifo_block, where fifo_block = full & ~pop.
  - s_wr, s_size, s_addr, s_wdata are muxed from master sel.
- Accept: accept = s_req & s_addr_ok. On accept:
  - m_addr_ok[sel]=1, all other bits 0, same cycle.
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NUM_MASTERS.
  - lock_valid <= 0.
- Lock:
  - If s_req=1 and s_addr_ok=0: lock_valid<=1, lock_idx<=sel.
  - This keeps the presented request stable until accepted, as the SRAM-like protocol requires.
  - If the locked master drops m_req (protocol violation): lock_valid<=0 and protocol_err<=1.
- Response:
  - On s_data_ok with FIFO non-empty: pop the head index h; m_data_ok[h]=1 and m_rdata=s_rdata in the same cycle (zero added latency).
  - On s_data_ok with FIFO empty: no m_data_ok, protocol_err<=1.
- Simultaneous push and pop:
  - Allowed in the same cycle at any occupancy, including full.
  - outstanding is unchanged.
- Full: with FIFO full and no pop, s_req=0 and no m_addr_ok. The lock is held if already set.
- Empty: outstanding=0; s_data_ok is ignored apart from setting the error flag.
- FIFO: circular buffer of depth MAX_OUTSTANDING.
  - Read/write pointers have one extra wrap bit.
  - full = (ptr low bits equal) & (wrap bits differ).
- outstanding = wptr - rptr, registered, updated each cycle.
- protocol_err is cleared only by reset.
- No combinational path from m_* inputs to m_data_ok.

Decomposition:
- Shared package sram_bus_pkg: SRAM size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and a clog2-safe width helper.
- One sub-module: id_fifo (parametrised WIDTH/DEPTH; push, pop, head, full, empty, count). It is reused later by a multi-outstanding cpu_axi_interface.
- Round-robin select stays inline.

Test Plan:
- Single master, N=3: m_req[1]=1, addr 0x1FC0_0000, read; s_addr_ok=1 in cycle 0 and s_data_ok=1 in cycle 2 with s_rdata=0xDEADBEEF -> m_addr_ok=3'b010 in cycle 0; m_data_ok=3'b010 and m_rdata=0xDEADBEEF in cycle 2; outstanding 0->1->0.
- Round robin: all three masters request continuously, s_addr_ok=1 every cycle -> accept order 0,1,2,0; responses return in that order with the matching one-hot m_data_ok.
- Lock: master 2 is presented with s_addr_ok=0 for 3 cycles while master 0 also requests, and rr_ptr favours 0 after lock -> s_addr stays master 2's address all 3 cycles; master 2 is accepted first.
- Full: MAX_OUTSTANDING=4, four accepts with no s_data_ok -> fifth request sees s_req=0 and outstanding=4; then push and pop in the same cycle -> outstanding stays 4 and m_addr_ok=1.
- Error: s_data_ok=1 with the FIFO empty -> no m_data_ok, protocol_err=1 from the next cycle, held until reset.
- Reset mid-flight: 2 outstanding, aresetn pulsed low mid-cycle -> outstanding, s_req, m_addr_ok and protocol_err go to 0 immediately, without waiting for an aclk edge.
